// File: rtl/reg_tag_scoreboard.sv
// Destination-tag scoreboard for in-flight instructions after decode.
// Selects the youngest forwarding stage per source operand and requests a stall on unready producers.
module reg_tag_scoreboard #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LAT_BITS = 3,
  parameter int unsigned SELW     = 2,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC*REG_BITS-1:0]  src_reg_D,
  input  logic [NUM_SRC-1:0]           src_on_D,
  input  logic [REG_BITS-1:0]          dst_reg_D,
  input  logic                         dst_we_D,
  input  logic [LAT_BITS-1:0]          dst_lat_D,
  input  logic [STAGES-1:0]            stall_stage,
  input  logic [STAGES-1:0]            flush_stage,
  input  logic                         clr_cnt,
  output logic [NUM_SRC*SELW-1:0]      fwd_sel,
  output logic                         stall_req,
  output logic [CNT_BITS-1:0]          stall_cnt
);

  // Index j holds entry j+1 (j=0 is E).
  logic [STAGES-1:0]               valid_q, valid_d, ld_valid;
  logic [STAGES-1:0][REG_BITS-1:0] tag_q, tag_d, ld_tag;
  logic [STAGES-1:0][LAT_BITS-1:0] cnt_q, cnt_d, ld_cnt;
  logic [CNT_BITS-1:0]             stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]              src_stall;

  function automatic logic [LAT_BITS-1:0] sat_dec(input logic [LAT_BITS-1:0] c);
    return (c == '0) ? '0 : c - LAT_BITS'(1);
  endfunction

  always_comb begin
    ld_valid    = '0;
    ld_tag      = '0;
    ld_cnt      = '0;
    ld_valid[0] = dst_we_D && (dst_reg_D != '0);
    ld_tag[0]   = dst_reg_D;
    ld_cnt[0]   = dst_lat_D;
    for (int unsigned i = 1; i < STAGES; i++) begin
      ld_valid[i] = valid_q[i-1];
      ld_tag[i]   = tag_q[i-1];
      ld_cnt[i]   = sat_dec(cnt_q[i-1]);
    end
  end

  // Flush beats stall beats load; a held entry keeps counting down.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < STAGES; i++) begin
      cnt_d[i] = sat_dec(cnt_q[i]);
      if (flush_stage[i]) begin
        valid_d[i] = 1'b0;
      end else if (!stall_stage[i]) begin
        valid_d[i] = ld_valid[i];
        tag_d[i]   = ld_tag[i];
        cnt_d[i]   = ld_cnt[i];
      end
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_BITS-1:0] sreg;
    logic                active;
    logic                found;
    logic                kready;
    logic [SELW-1:0]     ksel;

    assign sreg   = src_reg_D[s*REG_BITS +: REG_BITS];
    assign active = src_on_D[s] && (sreg != '0);

    // First hit scanning from entry 1 is the youngest producer; older hits are ignored.
    always_comb begin
      found  = 1'b0;
      kready = 1'b0;
      ksel   = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (!found && active && valid_q[i] && (tag_q[i] == sreg)) begin
          found  = 1'b1;
          kready = (cnt_q[i] == '0);
          ksel   = SELW'(i + 1);
        end
      end
    end

    assign fwd_sel[s*SELW +: SELW] = (found && kready) ? ksel : '0;
    assign src_stall[s]            = found && !kready;
  end

  assign stall_req = |src_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt)
      stall_cnt_d = '0;
    else if (stall_req && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_tag_scoreboard.sv
// Directed scoreboard bench for reg_tag_scoreboard: expectations are queued as stimulus is
// applied and popped against the combinational outputs before the next clock edge.
module tb_reg_tag_scoreboard;

  logic        clk;
  logic        reset;
  logic [9:0]  src_reg_D;
  logic [1:0]  src_on_D;
  logic [4:0]  dst_reg_D;
  logic        dst_we_D;
  logic [2:0]  dst_lat_D;
  logic [2:0]  stall_stage;
  logic [2:0]  flush_stage;
  logic        clr_cnt;
  logic [3:0]  fwd_sel;
  logic        stall_req;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] f0;
    logic [1:0] f1;
    logic       st;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];

  reg_tag_scoreboard #(
    .REG_BITS(5), .STAGES(3), .NUM_SRC(2), .LAT_BITS(3), .SELW(2), .CNT_BITS(16)
  ) dut (
    .clk(clk), .reset(reset),
    .src_reg_D(src_reg_D), .src_on_D(src_on_D),
    .dst_reg_D(dst_reg_D), .dst_we_D(dst_we_D), .dst_lat_D(dst_lat_D),
    .stall_stage(stall_stage), .flush_stage(flush_stage), .clr_cnt(clr_cnt),
    .fwd_sel(fwd_sel), .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [1:0] f0, input logic [1:0] f1,
                          input logic st, input int cnt);
    exp_t e;
    e.tag = tag; e.f0 = f0; e.f1 = f1; e.st = st; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic settle_compare();
    exp_t e;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_fwd"}, 32'(fwd_sel), 32'({e.f1, e.f0}));
      chk({e.tag, "_stall"}, 32'(stall_req), 32'(e.st));
      if (e.cnt >= 0) chk({e.tag, "_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    end
  endtask

  task automatic idle();
    src_reg_D = '0; src_on_D = '0;
    dst_reg_D = '0; dst_we_D = 1'b0; dst_lat_D = '0;
    stall_stage = '0; flush_stage = '0; clr_cnt = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_src(input int s, input logic [4:0] r, input logic on);
    src_reg_D[s*5 +: 5] = r;
    src_on_D[s]         = on;
  endtask

  task automatic set_dec(input logic [4:0] r, input logic [2:0] lat);
    dst_we_D = 1'b1; dst_reg_D = r; dst_lat_D = lat;
  endtask

  initial begin
    idle();
    // Reset with random inputs
    reset = 1'b0;
    src_reg_D = 10'($urandom); src_on_D = 2'($urandom);
    dst_reg_D = 5'($urandom); dst_we_D = 1'b1; dst_lat_D = 3'($urandom);
    stall_stage = 3'($urandom); flush_stage = 3'($urandom); clr_cnt = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    src_reg_D = 10'($urandom); src_on_D = 2'b11;
    push_exp("rst", 2'd0, 2'd0, 1'b0, 0);
    settle_compare();

    reset = 1'b1;
    idle();
    set_src(0, 5'd1, 1'b1); set_src(1, 5'd2, 1'b1);
    push_exp("rel0", 2'd0, 2'd0, 1'b0, 0);
    settle_compare();
    next_cycle();
    set_src(0, 5'd1, 1'b1); set_src(1, 5'd2, 1'b1);
    push_exp("rel1", 2'd0, 2'd0, 1'b0, 0);
    settle_compare();

    // Forwarding walk through E/M/W
    next_cycle(); set_dec(5'd3, 3'd0);
    next_cycle(); set_src(0, 5'd3, 1'b1); push_exp("fwdE", 2'd1, 2'd0, 1'b0, 0); settle_compare();
    next_cycle(); set_src(0, 5'd3, 1'b1); push_exp("fwdM", 2'd2, 2'd0, 1'b0, 0); settle_compare();
    next_cycle(); set_src(0, 5'd3, 1'b1); push_exp("fwdW", 2'd3, 2'd0, 1'b0, 0); settle_compare();
    next_cycle(); set_src(0, 5'd3, 1'b1); push_exp("fwdGone", 2'd0, 2'd0, 1'b0, 0); settle_compare();

    // Load-use stall, then bubble via flush of entry 1
    next_cycle(); set_dec(5'd5, 3'd1);
    next_cycle(); set_src(1, 5'd5, 1'b1); flush_stage = 3'b001;
    push_exp("ldUse", 2'd0, 2'd0, 1'b1, 0); settle_compare();
    next_cycle(); set_src(1, 5'd5, 1'b1);
    push_exp("ldFwd", 2'd0, 2'd2, 1'b0, 1); settle_compare();

    // Youngest wins even when unready
    repeat (3) next_cycle();
    set_dec(5'd7, 3'd0);
    next_cycle(); set_dec(5'd7, 3'd2);
    next_cycle(); set_src(0, 5'd7, 1'b1);
    push_exp("young", 2'd0, 2'd0, 1'b1, 1); settle_compare();
    repeat (3) next_cycle();
    push_exp("stcnt2", 2'd0, 2'd0, 1'b0, 2); settle_compare();
    set_dec(5'd7, 3'd0);
    next_cycle(); set_dec(5'd7, 3'd0);
    next_cycle(); set_src(0, 5'd7, 1'b1);
    push_exp("youngRdy", 2'd1, 2'd0, 1'b0, 2); settle_compare();

    // Register 0 never tracked; inactive operand never forwards
    next_cycle(); set_dec(5'd0, 3'd0);
    next_cycle(); set_src(0, 5'd0, 1'b1);
    push_exp("r0", 2'd0, 2'd0, 1'b0, 2); settle_compare();
    set_dec(5'd4, 3'd0);
    next_cycle(); set_src(0, 5'd4, 1'b0); set_src(1, 5'd4, 1'b1);
    push_exp("srcOff", 2'd0, 2'd1, 1'b0, 2); settle_compare();

    // Held entry keeps counting down; flush beats stall
    repeat (3) next_cycle();
    set_dec(5'd9, 3'd4);
    next_cycle();
    next_cycle(); stall_stage = 3'b010; set_src(0, 5'd9, 1'b1);
    push_exp("hold3", 2'd0, 2'd0, 1'b1, 2); settle_compare();
    next_cycle(); stall_stage = 3'b010; set_src(0, 5'd9, 1'b1);
    push_exp("hold2", 2'd0, 2'd0, 1'b1, 3); settle_compare();
    next_cycle(); stall_stage = 3'b010; set_src(0, 5'd9, 1'b1);
    push_exp("hold1", 2'd0, 2'd0, 1'b1, 4); settle_compare();
    next_cycle(); stall_stage = 3'b010; set_src(0, 5'd9, 1'b1);
    push_exp("hold0", 2'd2, 2'd0, 1'b0, 5); settle_compare();
    flush_stage = 3'b010;
    next_cycle(); set_src(0, 5'd9, 1'b1);
    push_exp("flushE2", 2'd3, 2'd0, 1'b0, 5); settle_compare();

    // Counter saturation, clear priority, reset during stall
    set_dec(5'd10, 3'd7); set_src(0, 5'd10, 1'b1);
    repeat (65600) @(posedge clk);
    #1;
    push_exp("sat", 2'd0, 2'd0, 1'b1, 16'hFFFF); settle_compare();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    push_exp("clr", 2'd0, 2'd0, 1'b1, 0); settle_compare();
    @(posedge clk); #1;
    push_exp("cnt1", 2'd0, 2'd0, 1'b1, 1); settle_compare();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(); set_src(0, 5'd10, 1'b1);
    push_exp("rstStall", 2'd0, 2'd0, 1'b0, 0); settle_compare();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_tag_scoreboard.md
Name: reg_tag_scoreboard

Overview:
Parametrised successor to the pipeline register-tag tracker. It tracks destination-register tags of in-flight instructions through STAGES pipeline stages after decode. For each of NUM_SRC decode source operands it selects the youngest forwarding stage, and it raises a stall when the producer's result is not yet ready. Per-entry latency countdowns generalise load-use detection to multi-cycle producers (load, mul/div, audio/video ops). The block sits between decode and the hazard/forward muxes and replaces the fixed E/M/W compare network.

Parameters:
REG_BITS, 5, register index width
STAGES, 3, tracked stages after decode (entry 1 = E, entry STAGES = W)
NUM_SRC, 2, decode source operands checked
LAT_BITS, 3, width of the per-entry ready-latency countdown
SELW, 2, forward select width; must be at least clog2(STAGES+1)
CNT_BITS, 16, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
src_reg_D  in  NUM_SRC*REG_BITS  decode source register indices; operand s at [s*REG_BITS +: REG_BITS]
src_on_D  in  NUM_SRC  operand s is actually read
dst_reg_D  in  REG_BITS  decode destination register
dst_we_D  in  1  decode instruction writes dst_reg_D
dst_lat_D  in  LAT_BITS  cycles after entering entry 1 before the result is forwardable
stall_stage  in  STAGES  bit i-1 holds entry i
flush_stage  in  STAGES  bit i-1 clears entry i valid
clr_cnt  in  1  clears the stall counter
fwd_sel  out  NUM_SRC*SELW  per operand: 0 = regfile, k = forward from entry k
stall_req  out  1  some operand waits on an unready producer
stall_cnt  out  CNT_BITS  saturating count of stall_req cycles

Behaviour:
- Reset is sampled on the clk edge while reset==0. It clears every entry's valid, tag and count, and clears stall_cnt. fwd_sel and stall_req then read 0 from the next cycle.
- State per entry i (1..STAGES): valid, tag[REG_BITS], cnt[LAT_BITS].
- Entry 1 source is decode:
  - valid = dst_we_D & (dst_reg_D != 0); register 0 is never tracked.
  - tag = dst_reg_D; cnt = dst_lat_D.
- Entry i>1 source is entry i-1: valid, tag, cnt copied, with cnt decremented by 1 and saturating at 0.
- Per-cycle update priority for entry i, highest first:
  - flush_stage[i-1] clears valid (the tag may hold any value).
  - stall_stage[i-1] holds valid and tag, but cnt still decrements and saturates at 0.
  - Otherwise the entry loads from its source.
- The caller must not drop an unstalled entry. The block does not check ordering between stall and flush bits.
- Match, per operand s:
  - Operand s is active when src_on_D[s]=1 and the source register is non-zero.
  - hit(i) = active & valid(i) & (tag(i) == source register).
- Youngest wins: k is the lowest i with hit(i).
  - k exists and cnt(k)==0: fwd_sel[s]=k, no stall from s.
  - k exists and cnt(k)!=0: fwd_sel[s]=0, s requests a stall.
  - No hit: fwd_sel[s]=0.
  - An older matching entry is never used when a younger one exists, even if the younger one is unready.
- stall_req = OR over operands of their stall requests.
- fwd_sel and stall_req are combinational from registered state plus the decode inputs. There are no registered outputs, so decode sees a result 0 cycles after it becomes ready.
- stall_cnt increments on each clk edge where stall_req==1 and it is below all-ones. It saturates at all-ones.
- If clr_cnt and stall_req are both high in the same cycle, clr_cnt wins: the counter goes to 0.
- Reset during a stall clears everything on that edge. stall_req is 0 on the following cycle.

Test Plan:
- Hold reset=0 for 2 cycles with random inputs -> fwd_sel=0, stall_req=0, stall_cnt=0. After release with dst_we_D=0 and src r1/r2 -> outputs remain 0.
- Decode writes r3, lat 0. Next cycle, src0=r3 -> fwd_sel[0]=1, stall_req=0. One cycle later, src0=r3 -> fwd_sel[0]=2. Then 3, then 0 once the entry leaves W.
- Load-use: r5, lat 1. Next cycle, src1=r5 -> stall_req=1, fwd_sel[1]=0. Drive flush_stage[0]=1 and keep decode held. The following cycle -> fwd_sel[1]=2, stall_req=0, stall_cnt=1.
- Youngest wins: r7 lat 0 in entry 2 and r7 lat 2 in entry 1 -> stall_req=1, fwd_sel=0. Separately, r7 lat 0 in both entries -> fwd_sel=1.
- r0: dst_we_D=1, dst_reg_D=0, then src0=r0 -> fwd_sel=0, stall_req=0. With src_on_D[0]=0 and a matching tag -> fwd_sel[0]=0.
- Stall/flush: r9 lat 4 in entry 2, held by stall_stage[1]=1 -> cnt reaches 0 while held and fwd_sel=2. Assert stall and flush together on entry 2 -> entry cleared. stall_req held for 0xFFFF cycles -> stall_cnt stays 0xFFFF. clr_cnt=1 -> 0.
